// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared RTC register constants, table layout and sequencer types
// Purpose: constants shared by the init sequencer, its table ROM and the time-write path.
// Ports: none (package).
package rtc_pkg;

  localparam int IDX_W       = 4;
  localparam int TABLE_DEPTH = 13;

  // RTC register addresses
  localparam logic [7:0] RTC_ADDR_CTRL      = 8'h02;
  localparam logic [7:0] RTC_ADDR_CLK_BASE  = 8'h21;  // clock registers 0x21..0x28
  localparam logic [7:0] RTC_ADDR_CLK_LAST  = 8'h28;
  localparam logic [7:0] RTC_ADDR_TMR_BASE  = 8'h41;  // timer registers 0x41..0x43
  localparam logic [7:0] RTC_ADDR_TMR_LAST  = 8'h43;

  // Data values written during init
  localparam logic [7:0] RTC_CTRL_INIT  = 8'h08;
  localparam logic [7:0] RTC_CTRL_RUN   = 8'h00;
  localparam logic [7:0] RTC_DATA_CLEAR = 8'h00;

  // Table layout: index of first/last entry of each region
  localparam logic [IDX_W-1:0] IDX_CTRL_INIT = 4'd0;
  localparam logic [IDX_W-1:0] IDX_CTRL_RUN  = 4'd1;
  localparam logic [IDX_W-1:0] IDX_CLK_FIRST = 4'd2;
  localparam logic [IDX_W-1:0] IDX_CLK_LAST  = 4'd9;
  localparam logic [IDX_W-1:0] IDX_TMR_FIRST = 4'd10;
  localparam logic [IDX_W-1:0] IDX_TMR_LAST  = 4'd12;

  // Mode encoding
  localparam logic [1:0] MODE_FULL      = 2'd0;
  localparam logic [1:0] MODE_CLR_CLOCK = 2'd1;
  localparam logic [1:0] MODE_CLR_TIMER = 2'd2;
  localparam logic [1:0] MODE_ILLEGAL   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_FINISH   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/rtc_init_rom.sv
// rtl/rtc_init_rom.sv - RTC init table lookup and mode range decode
// Purpose: combinational table index -> {address, data}, and mode -> {first, last} range.
// Ports:
//   index       : table entry index (entries beyond the table read as 0)
//   mode        : table selection
//   entry_addr  : address of the indexed entry
//   entry_data  : data of the indexed entry
//   range_first : first index for mode
//   range_last  : last index for mode
//   mode_valid  : mode selects a real range
module rtc_init_rom
  import rtc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic [IDX_W-1:0]  index,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] entry_addr,
  output logic [DATA_W-1:0] entry_data,
  output logic [IDX_W-1:0]  range_first,
  output logic [IDX_W-1:0]  range_last,
  output logic              mode_valid
);

  // Entry lookup and range decode stay in separate processes so the entry
  // path (fed from the sequencer's next index) never loops back into the
  // range path (fed from the mode input).
  always_comb begin
    entry_addr = '0;
    entry_data = '0;
    if (index == IDX_CTRL_INIT) begin
      entry_addr = ADDR_W'(RTC_ADDR_CTRL);
      entry_data = DATA_W'(RTC_CTRL_INIT);
    end else if (index == IDX_CTRL_RUN) begin
      entry_addr = ADDR_W'(RTC_ADDR_CTRL);
      entry_data = DATA_W'(RTC_CTRL_RUN);
    end else if ((index >= IDX_CLK_FIRST) && (index <= IDX_CLK_LAST)) begin
      entry_addr = ADDR_W'(RTC_ADDR_CLK_BASE + 8'(index - IDX_CLK_FIRST));
      entry_data = DATA_W'(RTC_DATA_CLEAR);
    end else if ((index >= IDX_TMR_FIRST) && (index <= IDX_TMR_LAST)) begin
      entry_addr = ADDR_W'(RTC_ADDR_TMR_BASE + 8'(index - IDX_TMR_FIRST));
      entry_data = DATA_W'(RTC_DATA_CLEAR);
    end
  end

  always_comb begin
    range_first = '0;
    range_last  = '0;
    mode_valid  = 1'b0;
    case (mode)
      MODE_FULL: begin
        range_first = IDX_CTRL_INIT;
        range_last  = IDX_TMR_LAST;
        mode_valid  = 1'b1;
      end
      MODE_CLR_CLOCK: begin
        range_first = IDX_CLK_FIRST;
        range_last  = IDX_CLK_LAST;
        mode_valid  = 1'b1;
      end
      MODE_CLR_TIMER: begin
        range_first = IDX_TMR_FIRST;
        range_last  = IDX_TMR_LAST;
        mode_valid  = 1'b1;
      end
      default: begin
        range_first = '0;
        range_last  = '0;
        mode_valid  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rtc_init_sequencer.sv
// rtl/rtc_init_sequencer.sv - RTC init table write sequencer
// Purpose: walks the table range chosen by mode, holding each entry on the bus for
// HOLD_CYCLES cycles, optionally waiting for bus_ack (with timeout) before advancing.
// Ports:
//   clk, reset               : clock, asynchronous active-low reset
//   start, mode              : launch request and table selection (sampled in IDLE)
//   abort                    : terminate an active sequence with an error pulse
//   bus_ack                  : bus controller finished the current write
//   address, data_out, wr_en : current entry presented to the bus (0 when idle)
//   busy, done, error        : status; done and error are one-cycle pulses
module rtc_init_sequencer
  import rtc_pkg::*;
#(
  parameter int HOLD_CYCLES = 74,
  parameter int USE_ACK     = 0,
  parameter int ACK_TIMEOUT = 1023,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic              abort,
  input  logic              bus_ack,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(ACK_TIMEOUT);

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              err_event;
  logic              advance;
  logic [ADDR_W-1:0] entry_addr;
  logic [DATA_W-1:0] entry_data;
  logic [IDX_W-1:0]  range_first;
  logic [IDX_W-1:0]  range_last;
  logic              mode_valid;

  // The ROM looks up the *next* index so the registered outputs change on
  // the same edge as the state/index, keeping address/data glitch-free.
  rtc_init_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_rom (
    .index       (index_d),
    .mode        (mode),
    .entry_addr  (entry_addr),
    .entry_data  (entry_data),
    .range_first (range_first),
    .range_last  (range_last),
    .mode_valid  (mode_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      index_q    <= '0;
      last_q     <= '0;
      hold_cnt_q <= '0;
      to_cnt_q   <= '0;
      address_q  <= '0;
      data_out_q <= '0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
      to_cnt_q   <= to_cnt_d;
      address_q  <= address_d;
      data_out_q <= data_out_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    to_cnt_d   = to_cnt_q;
    err_event  = 1'b0;
    advance    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // start together with abort is dropped entirely
        if (start && !abort) begin
          if (mode_valid) begin
            state_d    = ST_HOLD;
            index_d    = range_first;
            last_d     = range_last;
            hold_cnt_d = HC_W'(1);
          end else begin
            err_event = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          if (USE_ACK != 0) begin
            state_d  = ST_WAIT_ACK;
            to_cnt_d = TO_W'(1);
          end else begin
            advance = 1'b1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
      ST_WAIT_ACK: begin
        // an ack on the final timeout cycle still wins
        if (bus_ack) begin
          advance = 1'b1;
        end else if (to_cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          err_event = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance) begin
      to_cnt_d = '0;
      if (index_q == last_q) begin
        state_d = ST_FINISH;
      end else begin
        state_d    = ST_HOLD;
        index_d    = index_q + IDX_W'(1);
        hold_cnt_d = HC_W'(1);
      end
    end

    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      err_event = 1'b1;
    end

    // Leaving the active states returns all bookkeeping to its reset value.
    if ((state_d == ST_IDLE) || (state_d == ST_FINISH)) begin
      index_d    = '0;
      last_d     = '0;
      hold_cnt_d = '0;
      to_cnt_d   = '0;
    end
  end

  always_comb begin
    busy_d     = (state_d == ST_HOLD) || (state_d == ST_WAIT_ACK);
    wr_en_d    = busy_d;
    address_d  = busy_d ? entry_addr : '0;
    data_out_d = busy_d ? entry_data : '0;
    done_d     = (state_d == ST_FINISH);
    error_d    = err_event;
  end

  assign address  = address_q;
  assign data_out = data_out_q;
  assign wr_en    = wr_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_rtc_init_sequencer.sv
// tb/tb_rtc_init_sequencer.sv - scoreboard bench for rtc_init_sequencer
module tb_rtc_init_sequencer;

  localparam int H  = 74;
  localparam int TO = 20;
  localparam int K_ENTRY = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int kind;
    int addr;
    int data;
    int cyc;
  } ev_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start0 = 1'b0, abort0 = 1'b0, ack0 = 1'b0;
  logic       start1 = 1'b0, abort1 = 1'b0, ack1 = 1'b0;
  logic [1:0] mode0 = 2'd0, mode1 = 2'd0;
  logic [7:0] addr0, data0, addr1, data1;
  logic       wr0, busy0, done0, err0;
  logic       wr1, busy1, done1, err1;

  int cyc = 0;
  int compared = 0;
  int failed = 0;
  bit finishing = 1'b0;
  bit final_checked = 1'b0;

  // expected-event queues: written by stimulus only, read by the monitor via rd pointers
  ev_t exp_q0[$];
  ev_t exp_q1[$];
  int  rd0 = 0;
  int  rd1 = 0;

  // reference model scratch
  ev_t m_evs[$];
  int  m_acks[$];
  int  m_strays[$];
  int  m_s, m_abort, m_last;
  int  dly_cfg[13];

  bit  pbusy[2];
  int  paddr[2];
  int  pdata[2];

  int addr_t[13]  = '{'h02, 'h02, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27, 'h28, 'h41, 'h42, 'h43};
  int data_t[13]  = '{'h08, 'h00, 'h00, 'h00, 'h00, 'h00, 'h00, 'h00, 'h00, 'h00, 'h00, 'h00, 'h00};
  int first_t[3]  = '{0, 2, 10};
  int last_t[3]   = '{12, 9, 12};

  rtc_init_sequencer #(
    .HOLD_CYCLES (H), .USE_ACK (0), .ACK_TIMEOUT (1023), .ADDR_W (8), .DATA_W (8)
  ) dut0 (
    .clk (clk), .reset (reset), .start (start0), .mode (mode0), .abort (abort0),
    .bus_ack (ack0), .address (addr0), .data_out (data0), .wr_en (wr0),
    .busy (busy0), .done (done0), .error (err0)
  );

  rtc_init_sequencer #(
    .HOLD_CYCLES (H), .USE_ACK (1), .ACK_TIMEOUT (TO), .ADDR_W (8), .DATA_W (8)
  ) dut1 (
    .clk (clk), .reset (reset), .start (start1), .mode (mode1), .abort (abort1),
    .bus_ack (ack1), .address (addr1), .data_out (data1), .wr_en (wr1),
    .busy (busy1), .done (done1), .error (err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic ev_t mk(input int kind, input int a, input int d, input int c);
    ev_t e;
    e.kind = kind;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic expect_ev(input int which, input int kind, input int a, input int d);
    ev_t e;
    bit  have;
    have = 1'b0;
    compared++;
    if (which == 0) begin
      if (rd0 < exp_q0.size()) begin e = exp_q0[rd0]; rd0++; have = 1'b1; end
    end else begin
      if (rd1 < exp_q1.size()) begin e = exp_q1[rd1]; rd1++; have = 1'b1; end
    end
    if (!have) begin
      failed++;
      $display("FAIL dut%0d event: got kind=%0d addr=%02h data=%02h cyc=%0d, required no event",
               which, kind, a, d, cyc);
    end else if (e.kind != kind || e.addr != a || e.data != d || e.cyc != cyc) begin
      failed++;
      $display("FAIL dut%0d event: got kind=%0d addr=%02h data=%02h cyc=%0d, required kind=%0d addr=%02h data=%02h cyc=%0d",
               which, kind, a, d, cyc, e.kind, e.addr, e.data, e.cyc);
    end
  endtask

  task automatic observe(input int which, input logic busy, input logic wr, input logic [7:0] a,
                         input logic [7:0] d, input logic dn, input logic er);
    compared++;
    if ((wr !== busy) || (!busy && (a !== 8'h00 || d !== 8'h00)) || ((dn || er) && busy)) begin
      failed++;
      $display("FAIL dut%0d output consistency cyc=%0d: busy=%b wr_en=%b addr=%02h data=%02h done=%b error=%b",
               which, cyc, busy, wr, a, d, dn, er);
    end
    if (busy && (!pbusy[which] || int'(a) != paddr[which] || int'(d) != pdata[which]))
      expect_ev(which, K_ENTRY, int'(a), int'(d));
    if (dn) expect_ev(which, K_DONE, 0, 0);
    if (er) expect_ev(which, K_ERR, 0, 0);
    pbusy[which] = busy;
    paddr[which] = int'(a);
    pdata[which] = int'(d);
  endtask

  task automatic check_reset(input int which, input logic busy, input logic wr, input logic [7:0] a,
                             input logic [7:0] d, input logic dn, input logic er);
    compared++;
    if ({busy, wr, a, d, dn, er} !== 20'h0) begin
      failed++;
      $display("FAIL dut%0d reset outputs cyc=%0d: busy=%b wr_en=%b addr=%02h data=%02h done=%b error=%b, required all 0",
               which, cyc, busy, wr, a, d, dn, er);
    end
    pbusy[which] = 1'b0;
    paddr[which] = 0;
    pdata[which] = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check_reset(0, busy0, wr0, addr0, data0, done0, err0);
      check_reset(1, busy1, wr1, addr1, data1, done1, err1);
    end else begin
      observe(0, busy0, wr0, addr0, data0, done0, err0);
      observe(1, busy1, wr1, addr1, data1, done1, err1);
    end
    if (finishing && !final_checked) begin
      compared++;
      if (rd0 != exp_q0.size()) begin
        failed++;
        $display("FAIL dut0 pending events: consumed %0d, required %0d", rd0, exp_q0.size());
      end
      compared++;
      if (rd1 != exp_q1.size()) begin
        failed++;
        $display("FAIL dut1 pending events: consumed %0d, required %0d", rd1, exp_q1.size());
      end
      final_checked = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  // Builds the expected event timeline for one start request issued in the current cycle.
  task automatic build(input int which, input int m, input int abort_rel);
    int  s, v, w, first, n, end_c;
    bit  use_ack;
    s = cyc;
    m_s = s;
    m_evs.delete();
    m_acks.delete();
    m_strays.delete();
    use_ack = (which == 1);
    m_abort = (abort_rel < 0) ? -1 : s + abort_rel;
    if (m_abort == s) begin
      // start with abort in the same idle cycle: nothing happens
    end else if (m == 3) begin
      m_evs.push_back(mk(K_ERR, 0, 0, s + 1));
    end else begin
      first = first_t[m];
      n = last_t[m] - first + 1;
      v = s + 1;
      end_c = -1;
      for (int k = 0; k < n; k++) begin
        m_evs.push_back(mk(K_ENTRY, addr_t[first + k], data_t[first + k], v));
        m_strays.push_back(v + int'($urandom_range(H - 1, 0)));
        w = v + H;
        if (!use_ack) begin
          v = w;
        end else if (dly_cfg[k] == 0) begin
          m_evs.push_back(mk(K_ERR, 0, 0, w + TO));
          end_c = w + TO - 1;
          break;
        end else begin
          m_acks.push_back(w + dly_cfg[k] - 1);
          v = w + dly_cfg[k];
        end
      end
      if (end_c < 0) begin
        m_evs.push_back(mk(K_DONE, 0, 0, v));
        end_c = v;
      end
      if (m_abort > s && m_abort <= end_c) begin
        while (m_evs.size() > 0 && m_evs[m_evs.size() - 1].cyc > m_abort) void'(m_evs.pop_back());
        m_evs.push_back(mk(K_ERR, 0, 0, m_abort + 1));
      end
    end
    m_last = (m_evs.size() > 0) ? m_evs[m_evs.size() - 1].cyc : s;
  endtask

  task automatic push_evs(input int which, input int before_c);
    foreach (m_evs[i]) begin
      if (m_evs[i].cyc < before_c) begin
        if (which == 0) exp_q0.push_back(m_evs[i]);
        else            exp_q1.push_back(m_evs[i]);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input int m, input int stop_c);
    for (int c = m_s; c <= stop_c; c++) begin
      bit st, ab, ak;
      st = (c == m_s);
      ab = (c == m_abort);
      ak = 1'b0;
      foreach (m_acks[i])   if (m_acks[i] == c)   ak = 1'b1;
      foreach (m_strays[i]) if (m_strays[i] == c) ak = 1'b1;
      if (which == 0) begin
        start0 = st; mode0 = 2'(m); abort0 = ab; ack0 = ak;
      end else begin
        start1 = st; mode1 = 2'(m); abort1 = ab; ack1 = ak;
      end
      tick();
    end
    start0 = 1'b0; abort0 = 1'b0; ack0 = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; ack1 = 1'b0;
  endtask

  task automatic run(input int which, input int m, input int abort_rel);
    build(which, m, abort_rel);
    push_evs(which, 32'h7fffffff);
    drive(which, m, m_last + 2);
  endtask

  initial begin
    int r;
    foreach (dly_cfg[k]) dly_cfg[k] = 10;
    #2 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // USE_ACK=0 directed
    run(0, 0, -1);         // full init, done at start+963
    run(0, 2, -1);         // clear timer, done at start+223
    run(0, 1, -1);         // clear clock, done at start+593
    run(0, 3, -1);         // illegal mode: error only
    run(0, 0, 0);          // start+abort together: no activity
    run(0, 0, 3 * H + 30); // abort on entry 3, cycle 30

    // asynchronous reset mid-HOLD on entry 5, then a clean restart
    build(0, 0, -1);
    r = m_s + 1 + 5 * H + 20;
    push_evs(0, r);
    drive(0, 0, r - 1);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    run(0, 0, -1);

    // USE_ACK=1 directed: ack 10 cycles into each wait, then a timeout
    run(1, 2, -1);
    dly_cfg[0] = 0;
    run(1, 2, -1);
    dly_cfg[0] = 20;       // ack on the last allowed wait cycle
    run(1, 2, -1);

    // randomized
    for (int i = 0; i < 8; i++) begin
      int m, ab;
      m  = int'($urandom_range(3, 0));
      ab = ($urandom_range(2, 0) == 0) ? int'($urandom_range(1000, 0)) : -1;
      run(0, m, ab);
    end
    for (int i = 0; i < 8; i++) begin
      int m, ab;
      m  = int'($urandom_range(3, 0));
      ab = ($urandom_range(2, 0) == 0) ? int'($urandom_range(1000, 0)) : -1;
      foreach (dly_cfg[k]) dly_cfg[k] = ($urandom_range(14, 0) == 0) ? 0 : int'($urandom_range(TO, 1));
      run(1, m, ab);
    end

    finishing = 1'b1;
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule

// File: doc/rtc_init_sequencer.md
# rtc_init_sequencer

Parametrised write sequencer that issues a fixed table of address/data writes to the RTC bus controller after reset or on command. It supports three table modes: full init, clear clock, and clear timer. It holds each entry for a programmable number of cycles, with optional acknowledge handshake and timeout. It sits between the top-level control FSM (which issues `start`/`abort`) and the RTC bus interface (which consumes `address`, `data_out`, `wr_en` and returns `bus_ack`).

## Interface
- `HOLD_CYCLES`, 74: cycles each entry is held on the bus (≥2).
- `USE_ACK`, 0: 1 = after hold, wait for `bus_ack` before advancing.
- `ACK_TIMEOUT`, 1023: max cycles in ack wait before error (USE_ACK=1 only).
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset asserted).
- `start` in 1: one-cycle request; sampled only in IDLE.
- `mode` in 2: table selection, sampled with `start`: 0 full, 1 clear clock, 2 clear timer, 3 illegal.
- `abort` in 1: terminate sequence; priority over everything except reset.
- `bus_ack` in 1: bus controller completed current write.
- `address` out ADDR_W: current entry address; 0 when not busy.
- `data_out` out DATA_W: current entry data; 0 when not busy.
- `wr_en` out 1: high while an entry is presented (HOLD and WAIT_ACK).
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse on normal completion.
- `error` out 1: one-cycle pulse on abort, timeout, or illegal mode.

## Operation
- Table, 13 entries, index:addr/data:
  - 0: 02/08
  - 1: 02/00
  - 2–9: 21..28/00
  - 10–12: 41..43/00
- Mode ranges:
  - 0 = entries 0..12
  - 1 = entries 2..9
  - 2 = entries 10..12
- States: IDLE, HOLD, WAIT_ACK, FINISH.
- IDLE:
  - `start` with mode 0–2 → HOLD, index = range first, hold counter = 1.
  - `start` with mode 3 → `error` pulse, stay IDLE.
- HOLD:
  - Counter increments each cycle.
  - At counter == HOLD_CYCLES: if USE_ACK → WAIT_ACK; else if index == last → FINISH; else index+1, counter = 1.
- WAIT_ACK:
  - `bus_ack` → advance as above (back to HOLD or to FINISH).
  - Timeout counter reaching ACK_TIMEOUT → `error`, IDLE.
- FINISH: `done`=1 for one cycle → IDLE.
- `abort` in any non-IDLE state → IDLE next cycle, `error` pulse; `abort` in IDLE ignored. Simultaneous `start`+`abort` in IDLE: start ignored.
- `start` while busy ignored.
- `bus_ack` outside WAIT_ACK ignored.
- Reset (any time, mid-sequence included): state IDLE, index 0, counters cleared, all outputs 0.

## Timing
- All outputs registered; reset value of every output is 0.
- Cycle 0: `start` sampled. From cycle 1: `busy`=`wr_en`=1, `address`/`data_out` = first entry.
- USE_ACK=0: each entry visible exactly HOLD_CYCLES cycles; n entries occupy cycles 1..n·HOLD_CYCLES.
  - `done` pulses at cycle n·HOLD_CYCLES+1, with `busy`=`wr_en`=0 and `address`=0 that cycle.
  - Default mode 0: 962 active cycles, `done` at cycle 963.
- USE_ACK=1: `bus_ack` at cycle t in WAIT_ACK → next entry visible from t+1 (or `done` at t+1 if last).
- Abort at cycle t → outputs 0 and `error`=1 at t+1.
- Address/data transitions only on entry boundaries; no glitch between entries (registered outputs).
- Counter widths: $clog2(HOLD_CYCLES+1), $clog2(ACK_TIMEOUT+1), 4-bit index. No wrap: counters reset on every entry advance.

## Structure
- Shared package `rtc_pkg`:
  - RTC register address constants (0x02, 0x21–0x28, 0x41–0x43) and control init values 0x08/0x00.
  - Mode encoding constants.
  - Table depth constant 13.
- Sub-module `rtc_init_rom`: combinational index → {address, data} lookup plus mode → {first, last} range. Keeps the table separate from the FSM for reuse by the time-write path.
- Tristating onto the shared bus is done at top level, gated by `busy`; this block never drives Z.

## Test plan
- Reset low mid-HOLD at entry 5 → next cycle all outputs 0; after release, `start` mode 0 restarts at address 0x02 data 0x08.
- HOLD_CYCLES=74, USE_ACK=0, `start` mode 0 → 13 entries, each address held 74 cycles in order 02,02,21..28,41..43; `done` at cycle 963.
- `start` mode 2 → addresses 41,42,43 each 74 cycles, `done` at cycle 223; mode 1 → 21..28, `done` at cycle 593.
- USE_ACK=1, `bus_ack` delayed 10 cycles per entry, mode 2 → each entry visible 84 cycles, `done` after third ack+1; a stray `bus_ack` during HOLD has no effect.
- USE_ACK=1, ACK_TIMEOUT=20, no ack → `error` pulse 20 cycles after entering WAIT_ACK, `busy`=0.
- `abort` at entry 3 cycle 30 → `error` next cycle, outputs 0; `start` mode 3 → `error`, `busy` stays 0; `start`+`abort` together in IDLE → no activity.
